// File: rtl/led_blink_drv.sv
// LED burst blinker: on request, blinks the LED N times (on/off phases) followed by a
// gap, then pulses o_Done. One further request can be queued while a burst runs.
module led_blink_drv #(
  parameter int pOnPeriod  = 12500000,
  parameter int pOffPeriod = 12500000,
  parameter int pGapPeriod = 50000000,
  parameter int pTmrWidth  = 26
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Trig,
  input  logic [3:0] iv_BlinkCnt,
  output logic       o_Led,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Pend
);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  localparam logic [pTmrWidth-1:0] ON_LOAD  = pTmrWidth'(pOnPeriod - 1);
  localparam logic [pTmrWidth-1:0] OFF_LOAD = pTmrWidth'(pOffPeriod - 1);
  localparam logic [pTmrWidth-1:0] GAP_LOAD = pTmrWidth'(pGapPeriod - 1);

  state_t               state_q, state_d;
  logic [pTmrWidth-1:0] tmr_q, tmr_d;
  logic [3:0]           rem_q, rem_d;
  logic [3:0]           qcnt_q, qcnt_d;
  logic                 pend_q, pend_d;
  logic                 led_q, busy_q, done_q;
  logic                 trig_ok;
  logic                 tmr_exp;

  assign trig_ok = i_Trig && (iv_BlinkCnt != 4'd0);
  assign tmr_exp = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_exp ? tmr_q : tmr_q - pTmrWidth'(1);
    rem_d   = rem_q;
    qcnt_d  = qcnt_q;
    pend_d  = pend_q;

    // Requests arriving while busy go to the one-deep queue; latest one wins.
    if (trig_ok && state_q != IDLE) begin
      pend_d = 1'b1;
      qcnt_d = iv_BlinkCnt;
    end

    case (state_q)
      IDLE: begin
        if (trig_ok) begin
          state_d = ON;
          tmr_d   = ON_LOAD;
          rem_d   = iv_BlinkCnt;
        end
      end
      ON: begin
        if (tmr_exp) begin
          if (rem_q > 4'd1) begin
            state_d = OFF;
            tmr_d   = OFF_LOAD;
            rem_d   = rem_q - 4'd1;
          end else begin
            state_d = GAP;
            tmr_d   = GAP_LOAD;
          end
        end
      end
      OFF: begin
        if (tmr_exp) begin
          state_d = ON;
          tmr_d   = ON_LOAD;
        end
      end
      GAP: begin
        if (tmr_exp) begin
          // A request on this very edge has already been queued above, so launch qcnt_d.
          if (pend_d) begin
            state_d = ON;
            tmr_d   = ON_LOAD;
            rem_d   = qcnt_d;
          end else begin
            state_d = IDLE;
            rem_d   = 4'd0;
          end
          pend_d = 1'b0;
          qcnt_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
        rem_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      rem_q   <= 4'd0;
      qcnt_q  <= 4'd0;
      pend_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rem_q   <= rem_d;
      qcnt_q  <= qcnt_d;
      pend_q  <= pend_d;
      led_q   <= (state_d == ON);
      busy_q  <= (state_d != IDLE);
      // Done covers the final GAP cycle so a queued burst lights the LED right after it.
      done_q  <= (state_d == GAP) && (tmr_d == '0);
    end
  end

  assign o_Led  = led_q;
  assign o_Busy = busy_q;
  assign o_Done = done_q;
  assign o_Pend = pend_q;

endmodule

// File: tb/tb_led_blink_drv.sv
// Bench for led_blink_drv: vector table, directed burst sequences and randomized
// traffic against an elapsed-time reference model.
module tb_led_blink_drv;

  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic       led, busy, done, pend;

  led_blink_drv #(
    .pOnPeriod(ON), .pOffPeriod(OFF), .pGapPeriod(GAP), .pTmrWidth(8)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Trig(trig), .iv_BlinkCnt(cnt),
    .o_Led(led), .o_Busy(busy), .o_Done(done), .o_Pend(pend)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a burst is described by its count and elapsed cycle index.
  bit m_active, m_pend;
  int m_t, m_n, m_pcnt;

  function automatic int blen(int n);
    return n * ON + (n - 1) * OFF + GAP;
  endfunction

  function automatic bit exp_led();
    return m_active && (m_t < m_n * ON + (m_n - 1) * OFF) && ((m_t % (ON + OFF)) < ON);
  endfunction

  function automatic bit exp_done();
    return m_active && (m_t == blen(m_n) - 1);
  endfunction

  task automatic model_clear();
    m_active = 0; m_pend = 0; m_t = 0; m_n = 0; m_pcnt = 0;
  endtask

  task automatic model_edge(bit t_trig, int t_cnt, bit t_rst);
    bit ok;
    ok = t_trig && (t_cnt != 0);
    if (t_rst) begin
      model_clear();
    end else if (!m_active) begin
      if (ok) begin m_active = 1; m_t = 0; m_n = t_cnt; end
    end else if (m_t == blen(m_n) - 1) begin
      if (ok) begin m_t = 0; m_n = t_cnt; m_pend = 0; end
      else if (m_pend) begin m_t = 0; m_n = m_pcnt; m_pend = 0; end
      else m_active = 0;
    end else begin
      m_t++;
      if (ok) begin m_pend = 1; m_pcnt = t_cnt; end
    end
  endtask

  task automatic chk(string name, int act, int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
  endtask

  task automatic cmp_model(string tag);
    chk({tag, "_led"},  int'(led),  int'(exp_led()));
    chk({tag, "_busy"}, int'(busy), int'(m_active));
    chk({tag, "_done"}, int'(done), int'(exp_done()));
    chk({tag, "_pend"}, int'(pend), int'(m_pend));
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(bit t_trig, logic [3:0] t_cnt, bit t_rst);
    trig = t_trig; cnt = t_cnt; rst = t_rst;
    @(posedge clk);
    model_edge(t_trig, int'(t_cnt), t_rst);
    #1;
    trig = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; trig = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  typedef struct {
    bit trig; logic [3:0] cnt;
    bit led; bit busy; bit done; bit pend;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int rises, busy_cyc, done_cyc, led_cyc, busy_low, done_at;
    bit prev;
    logic [29:0] pat;

    vecs[0] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state
    model_clear();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pend", int'(pend), 0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].trig, vecs[i].cnt, 1'b0);
      $display("vec %0d trig=%0b cnt=%0d -> led=%0b busy=%0b done=%0b pend=%0b",
               i, vecs[i].trig, vecs[i].cnt, led, busy, done, pend);
      chk("vec_led",  int'(led),  int'(vecs[i].led));
      chk("vec_busy", int'(busy), int'(vecs[i].busy));
      chk("vec_done", int'(done), int'(vecs[i].done));
      chk("vec_pend", int'(pend), int'(vecs[i].pend));
    end

    // Count-3 burst: LED pattern, done position and busy length
    do_reset();
    pat = 30'b0000_00000000_1111_000_1111_000_1111;
    busy_cyc = 0; done_at = 0;
    for (int c = 1; c <= 30; c++) begin
      step(c == 1, 4'd3, 1'b0);
      cmp_model("b3");
      chk("b3_pattern", int'(led), int'(pat[c-1]));
      if (busy) busy_cyc++;
      if (done) done_at = c;
    end
    chk("b3_done_cycle", done_at, 26);
    chk("b3_busy_cycles", busy_cyc, 26);
    $display("burst3: busy=%0d done_at=%0d", busy_cyc, done_at);

    // Queued request overwritten, then launched with no busy gap
    do_reset();
    rises = 0; prev = 0; busy_low = 0; done_at = 0;
    for (int c = 1; c <= 55; c++) begin
      if (c == 1) step(1'b1, 4'd1, 1'b0);
      else if (c == 5) step(1'b1, 4'd2, 1'b0);
      else if (c == 7) step(1'b1, 4'd5, 1'b0);
      else step(1'b0, 4'd0, 1'b0);
      cmp_model("q");
      if (c == 6) chk("q_pend_set", int'(pend), 1);
      if (c == 12) chk("q_done", int'(done), 1);
      if (c == 13) begin
        chk("q_led_next", int'(led), 1);
        chk("q_pend_clr", int'(pend), 0);
      end
      if (c <= 52) begin
        if (!busy) busy_low++;
        if (led && !prev) rises++;
      end
      if (done) done_at = c;
      prev = led;
    end
    chk("q_busy_low", busy_low, 0);
    chk("q_blinks", rises, 6);
    chk("q_last_done", done_at, 52);
    $display("queue: blinks=%0d last_done=%0d", rises, done_at);

    // Trigger on the gap-expiry edge
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step(c == 1, 4'd1, 1'b0);
      cmp_model("ge");
    end
    chk("ge_done", int'(done), 1);
    step(1'b1, 4'd2, 1'b0);
    cmp_model("ge2");
    chk("ge_led", int'(led), 1);
    chk("ge_busy", int'(busy), 1);
    chk("ge_done_end", int'(done), 0);
    chk("ge_pend", int'(pend), 0);
    $display("gap-edge trigger: led=%0b busy=%0b", led, busy);

    // Asynchronous reset during the second ON with a queued request
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) step(1'b1, 4'd4, 1'b0);
      else if (c == 3) step(1'b1, 4'd6, 1'b0);
      else step(1'b0, 4'd0, 1'b0);
      cmp_model("ar");
    end
    chk("ar_pre_pend", int'(pend), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_led", int'(led), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_pend", int'(pend), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    busy_cyc = 0; done_cyc = 0; led_cyc = 0;
    for (int c = 0; c < 60; c++) begin
      step(1'b0, 4'd0, 1'b0);
      cmp_model("ar_idle");
      if (busy) busy_cyc++;
      if (done) done_cyc++;
      if (led) led_cyc++;
    end
    chk("ar_no_busy", busy_cyc, 0);
    chk("ar_no_done", done_cyc, 0);
    chk("ar_no_led", led_cyc, 0);
    $display("async reset: busy_after=%0d done_after=%0d", busy_cyc, done_cyc);

    // First edge after reset release accepts a trigger
    do_reset();
    step(1'b1, 4'd2, 1'b0);
    chk("first_edge_busy", int'(busy), 1);
    chk("first_edge_led", int'(led), 1);
    $display("first edge after reset: busy=%0b", busy);

    // Count-15 burst
    do_reset();
    rises = 0; prev = 0; busy_cyc = 0; done_cyc = 0;
    for (int c = 1; c <= 115; c++) begin
      step(c == 1, 4'd15, 1'b0);
      cmp_model("b15");
      if (led && !prev) rises++;
      prev = led;
      if (busy) busy_cyc++;
      if (done) done_cyc++;
    end
    chk("b15_blinks", rises, 15);
    chk("b15_length", busy_cyc, 110);
    chk("b15_done_pulses", done_cyc, 1);
    $display("burst15: blinks=%0d length=%0d", rises, busy_cyc);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit        r_trig, r_rst;
      logic [3:0] r_cnt;
      r_trig = ($urandom % 30) == 0;
      r_cnt  = (($urandom % 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      r_rst  = ($urandom % 500) == 0;
      step(r_trig, r_cnt, r_rst);
      cmp_model("rnd");
    end
    $display("random: 3000 cycles");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
